// File: rtl/lcd_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen_if
// Description : Pixel-source handshake between lcd_timing_gen and an upstream
//               pixel source. The generator requests a pixel and publishes its
//               active-area coordinate. The source answers with an RGB565
//               value in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_timing_gen_if #(
    parameter int CW = 16
);
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [15:0]   pix_rgb;

    modport master (output pix_req, output pix_x, output pix_y, input pix_rgb);
    modport slave  (input pix_req, input pix_x, input pix_y, output pix_rgb);
endinterface
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen
// Description : Parametrised RGB565 LCD timing and test-pattern generator.
//               It produces HSYNC/VSYNC/DE with programmable porches and
//               polarities, and a per-pixel request with coordinates. RGB
//               comes from built-in bars, gradient or checker patterns, or
//               from a solid colour or pass-through pixel in mode 3.
//               Optional feature macro: LCD_TIMING_GEN_PASSTHRU_EN
//               (mode 3 forwards pix_rgb instead of solid_rgb).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_SYNC   = 1,
    parameter int   H_BP     = 182,
    parameter int   H_FP     = 210,
    parameter int   V_ACTIVE = 480,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 0,
    parameter int   V_FP     = 45,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 16
) (
    input  wire              PixelClk,
    input  wire              nRST,
    input  wire  [1:0]       mode,
    input  wire  [15:0]      solid_rgb,
    lcd_timing_gen_if.master pix,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic             LCD_DE,
    output logic [4:0]       LCD_R,
    output logic [5:0]       LCD_G,
    output logic [4:0]       LCD_B,
    output logic             sof,
    output logic [7:0]       frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

    localparam logic [CW-1:0] c_H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_SYNC      = CW'(H_SYNC);
    localparam logic [CW-1:0] c_V_SYNC      = CW'(V_SYNC);
    localparam logic [CW-1:0] c_H_ACT_FIRST = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] c_H_ACT_LAST  = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CW-1:0] c_V_ACT_FIRST = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] c_V_ACT_LAST  = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [CW-1:0] c_BAR_DIV     = CW'(BAR_DIV);
    localparam logic [CW-1:0] c_BAR_LIMIT   = CW'(8 * BAR_W);

    localparam logic [15:0] c_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_CYAN    = 16'h07FF;
    localparam logic [15:0] c_GREEN   = 16'h07E0;
    localparam logic [15:0] c_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_RED     = 16'hF800;
    localparam logic [15:0] c_BLUE    = 16'h001F;
    localparam logic [15:0] c_BLACK   = 16'h0000;

    // Reject geometries the counters and pattern logic cannot represent.
    generate
        if (H_SYNC < 1 || H_ACTIVE < 1 || V_SYNC < 1 || V_ACTIVE < 1 ||
            H_BP < 0 || H_FP < 0 || V_BP < 0 || V_FP < 0) begin : g_bad_geometry
            $error("lcd_timing_gen: SYNC/ACTIVE must be >= 1 and porches >= 0");
        end
        if (CW < 6 || CW > 31 ||
            (longint'(H_TOTAL) > (longint'(1) << CW)) ||
            (longint'(V_TOTAL) > (longint'(1) << CW))) begin : g_bad_cw
            $error("lcd_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [1:0]    r_mode;
    logic [15:0]   r_rgb;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_start;
    logic          w_req;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [CW-1:0] w_bar_idx;
    logic [15:0]   w_pat;
    logic [15:0]   w_mode3_rgb;

    assign w_h_last      = (r_h == c_H_LAST);
    assign w_v_last      = (r_v == c_V_LAST);
    assign w_frame_start = (r_h == '0) && (r_v == '0);
    assign w_req         = (r_h >= c_H_ACT_FIRST) && (r_h <= c_H_ACT_LAST) &&
                           (r_v >= c_V_ACT_FIRST) && (r_v <= c_V_ACT_LAST);
    assign w_x           = w_req ? (r_h - c_H_ACT_FIRST) : '0;
    assign w_y           = w_req ? (r_v - c_V_ACT_FIRST) : '0;
    assign w_bar_idx     = w_x / c_BAR_DIV;

    assign pix.pix_req = w_req;
    assign pix.pix_x   = w_x;
    assign pix.pix_y   = w_y;

    // Raster position: h sweeps a line, v advances on every line wrap.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : (r_v + 1'b1);
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Mode is latched only at the frame origin so a frame never mixes patterns.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_mode <= 2'd0;
        end else if (w_frame_start) begin
            r_mode <= mode;
        end
    end

`ifdef LCD_TIMING_GEN_PASSTHRU_EN
    // Mode 3 forwards the upstream pixel answering the current request.
    assign w_mode3_rgb = pix.pix_rgb;
    wire w_unused_solid = ^solid_rgb;
`else
    logic [15:0] r_solid;

    // Solid colour is shadowed alongside mode for tear-free updates.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_solid <= 16'h0000;
        end else if (w_frame_start) begin
            r_solid <= solid_rgb;
        end
    end

    assign w_mode3_rgb = r_solid;
    wire w_unused_pix_rgb = ^pix.pix_rgb;
`endif

    // Pattern colour for the currently requested pixel.
    always_comb begin
        w_pat = c_BLACK;
        case (r_mode)
            2'd0: begin
                // Pixels past the eighth bar (division remainder) stay black.
                if (w_x < c_BAR_LIMIT) begin
                    case (w_bar_idx)
                        'd0:     w_pat = c_WHITE;
                        'd1:     w_pat = c_YELLOW;
                        'd2:     w_pat = c_CYAN;
                        'd3:     w_pat = c_GREEN;
                        'd4:     w_pat = c_MAGENTA;
                        'd5:     w_pat = c_RED;
                        'd6:     w_pat = c_BLUE;
                        default: w_pat = c_BLACK;
                    endcase
                end
            end
            2'd1:    w_pat = {w_x[4:0], w_y[5:0], ~w_x[4:0]};
            2'd2:    w_pat = (w_x[5] ^ w_y[5]) ? c_WHITE : c_BLACK;
            default: w_pat = w_mode3_rgb;
        endcase
    end

    // Panel outputs: all registered together so they stay mutually aligned.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            LCD_HSYNC <= ~HS_POL;
            LCD_VSYNC <= ~VS_POL;
            LCD_DE    <= 1'b0;
            r_rgb     <= 16'h0000;
            sof       <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            LCD_HSYNC <= (r_h < c_H_SYNC) ? HS_POL : ~HS_POL;
            LCD_VSYNC <= (r_v < c_V_SYNC) ? VS_POL : ~VS_POL;
            LCD_DE    <= w_req;
            r_rgb     <= w_req ? w_pat : 16'h0000;
            sof       <= w_frame_start;
            if (w_h_last && w_v_last) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign LCD_R = r_rgb[15:11];
    assign LCD_G = r_rgb[10:5];
    assign LCD_B = r_rgb[4:0];
endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing_gen
// Description : Scoreboard bench for lcd_timing_gen on a 25x8 raster. A driver
//               issues per-cycle stimulus and queues the expected panel
//               response. A monitor pops and compares after each edge. A
//               second instance with inverted sync polarity shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;
    localparam int CW = 16;
    localparam int HT = 25;
    localparam int VT = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid = 16'h0000;

    always #5 clk = ~clk;

    lcd_timing_gen_if #(.CW(CW)) pif1 ();
    lcd_timing_gen_if #(.CW(CW)) pif2 ();

    logic       hs1, vs1, de1, sof1, hs2, vs2, de2, sof2;
    logic [4:0] r1, b1, r2, b2;
    logic [5:0] g1, g2;
    logic [7:0] fc1, fc2;

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_SYNC(2), .H_BP(3), .H_FP(4),
        .V_ACTIVE(4), .V_SYNC(1), .V_BP(1), .V_FP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) u_dut1 (
        .PixelClk(clk), .nRST(nrst), .mode(mode), .solid_rgb(solid), .pix(pif1),
        .LCD_HSYNC(hs1), .LCD_VSYNC(vs1), .LCD_DE(de1),
        .LCD_R(r1), .LCD_G(g1), .LCD_B(b1), .sof(sof1), .frame_cnt(fc1)
    );

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_SYNC(2), .H_BP(3), .H_FP(4),
        .V_ACTIVE(4), .V_SYNC(1), .V_BP(1), .V_FP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) u_dut2 (
        .PixelClk(clk), .nRST(nrst), .mode(mode), .solid_rgb(solid), .pix(pif2),
        .LCD_HSYNC(hs2), .LCD_VSYNC(vs2), .LCD_DE(de2),
        .LCD_R(r2), .LCD_G(g2), .LCD_B(b2), .sof(sof2), .frame_cnt(fc2)
    );

    typedef struct {
        logic        hs, vs, de, sof, req;
        logic [15:0] rgb, px, py;
        logic [7:0]  fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Hand-computed bar colours for a 16-pixel line (2 pixels per bar).
    logic [15:0] BAR [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0,
                              16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                              16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                              16'h001F, 16'h001F, 16'h0000, 16'h0000};

    // Reference raster state.
    int          mh = 0, mv = 0, mfc = 0;
    logic [1:0]  msh_mode = 2'd0;
    logic [15:0] msh_solid = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic is_act(input int h, input int v);
        return (h >= 5) && (h < 21) && (v >= 2) && (v < 6);
    endfunction

    function automatic logic [15:0] pattern(input logic [1:0] md, input int x, input int y,
                                            input logic [15:0] sol, input logic [15:0] prgb);
        logic [15:0] xs;
        logic [15:0] ys;
        xs = 16'(x);
        ys = 16'(y);
        case (md)
            2'd0:    pattern = BAR[x];
            2'd1:    pattern = {xs[4:0], ys[5:0], ~xs[4:0]};
            2'd2:    pattern = (xs[5] ^ ys[5]) ? 16'hFFFF : 16'h0000;
`ifdef LCD_TIMING_GEN_PASSTHRU_EN
            default: pattern = prgb;
`else
            default: pattern = sol;
`endif
        endcase
    endfunction

    // One cycle of stimulus: set inputs, queue the response to the next edge.
    task automatic drive_one();
        exp_t        e;
        logic        act_pre;
        logic [15:0] prgb;
        act_pre = is_act(mh, mv);
        prgb = act_pre ? 16'((mh - 5) * 16'h0101) : 16'hDEAD;
        pif1.pix_rgb = prgb;
        pif2.pix_rgb = prgb;
        e.hs  = !(mh < 2);
        e.vs  = !(mv < 1);
        e.de  = act_pre;
        e.rgb = act_pre ? pattern(msh_mode, mh - 5, mv - 2, msh_solid, prgb) : 16'h0000;
        e.sof = (mh == 0) && (mv == 0);
        if (mh == 0 && mv == 0) begin
            msh_mode  = mode;
            msh_solid = solid;
        end
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
                mv = 0;
                mfc = (mfc + 1) % 256;
            end else begin
                mv = mv + 1;
            end
        end else begin
            mh = mh + 1;
        end
        e.fc  = 8'(mfc);
        e.req = is_act(mh, mv);
        e.px  = e.req ? 16'(mh - 5) : 16'h0000;
        e.py  = e.req ? 16'(mv - 2) : 16'h0000;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hs1"},  {31'd0, hs1}, 32'd1);
        chk({tag, "_vs1"},  {31'd0, vs1}, 32'd1);
        chk({tag, "_hs2"},  {31'd0, hs2}, 32'd0);
        chk({tag, "_vs2"},  {31'd0, vs2}, 32'd0);
        chk({tag, "_de1"},  {31'd0, de1}, 32'd0);
        chk({tag, "_de2"},  {31'd0, de2}, 32'd0);
        chk({tag, "_rgb1"}, {16'd0, r1, g1, b1}, 32'd0);
        chk({tag, "_rgb2"}, {16'd0, r2, g2, b2}, 32'd0);
        chk({tag, "_sof1"}, {31'd0, sof1}, 32'd0);
        chk({tag, "_sof2"}, {31'd0, sof2}, 32'd0);
        chk({tag, "_fc1"},  {24'd0, fc1}, 32'd0);
        chk({tag, "_fc2"},  {24'd0, fc2}, 32'd0);
        chk({tag, "_req1"}, {31'd0, pif1.pix_req}, 32'd0);
    endtask

    // Monitor: compares every queued response just after the edge it targets.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hsync",  {31'd0, hs1}, {31'd0, e.hs});
            chk("vsync",  {31'd0, vs1}, {31'd0, e.vs});
            chk("de",     {31'd0, de1}, {31'd0, e.de});
            chk("rgb",    {16'd0, r1, g1, b1}, {16'd0, e.rgb});
            chk("sof",    {31'd0, sof1}, {31'd0, e.sof});
            chk("fcnt",   {24'd0, fc1}, {24'd0, e.fc});
            chk("pix_req", {31'd0, pif1.pix_req}, {31'd0, e.req});
            chk("pix_x",  {16'd0, pif1.pix_x}, {16'd0, e.px});
            chk("pix_y",  {16'd0, pif1.pix_y}, {16'd0, e.py});
            chk("hsync_pol1", {31'd0, hs2}, {31'd0, ~e.hs});
            chk("vsync_pol1", {31'd0, vs2}, {31'd0, ~e.vs});
            chk("de_pol1",    {31'd0, de2}, {31'd0, e.de});
            chk("rgb_pol1",   {16'd0, r2, g2, b2}, {16'd0, e.rgb});
        end
    end

    initial begin
        int sw;
        sw = 0;
        pif1.pix_rgb = 16'hDEAD;
        pif2.pix_rgb = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        chk_reset_values("por");
        nrst = 1'b1;

        // Four full frames plus part of a fifth, switching settings mid-frame
        // at (h=10, v=3); each change must only appear on the following frame.
        for (int c = 0; c < 4 * 200 + 112; c++) begin
            if (mh == 10 && mv == 3) begin
                case (sw)
                    0: mode = 2'd2;
                    1: mode = 2'd1;
                    2: begin mode = 2'd3; solid = 16'h1234; end
                    3: solid = 16'hABCD;
                    default: mode = 2'd0;
                endcase
                sw++;
            end
            drive_one();
        end

        // Mid-line asynchronous reset: outputs must take reset values at once.
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        chk_reset_values("async_rst");
        mh = 0;
        mv = 0;
        mfc = 0;
        msh_mode = 2'd0;
        msh_solid = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk_reset_values("rst_hold");
        nrst = 1'b1;
        for (int c = 0; c < 210; c++) begin
            drive_one();
        end
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
